// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines of 4 words.
// A miss stalls the core while whole blocks move to and from main memory.
module dcache_dm_wb #(
    parameter int ADDR_W         = 30,
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           proc_read,
    input  logic                           proc_write,
    input  logic [ADDR_W-1:0]              proc_addr,
    input  logic [31:0]                    proc_wdata,
    output logic [31:0]                    proc_rdata,
    output logic                           proc_stall,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [ADDR_W-3:0]              mem_addr,
    output logic [32*WORDS_PER_LINE-1:0]   mem_wdata,
    input  logic [32*WORDS_PER_LINE-1:0]   mem_rdata,
    input  logic                           mem_ready
);
    localparam int TAG_W   = ADDR_W - 5;
    localparam int BLOCK_W = 32 * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_arr [NUM_LINES];

    logic [2:0]       idx;
    logic [1:0]       off;
    logic [TAG_W-1:0] req_tag;
    logic [6:0]       word_lsb;
    logic             req;
    logic             hit;
    logic             fill;
    logic             store;

    logic               mem_read_n;
    logic               mem_write_n;
    logic [ADDR_W-3:0]  mem_addr_n;
    logic [BLOCK_W-1:0] mem_wdata_n;

    assign idx      = proc_addr[4:2];
    assign off      = proc_addr[1:0];
    assign req_tag  = proc_addr[ADDR_W-1:5];
    assign word_lsb = {off, 5'd0};
    assign req      = proc_read | proc_write;
    assign hit      = valid[idx] && (tag_arr[idx] == req_tag);

    assign proc_stall = req && !((state == COMPARE) && hit);

    always_comb begin
        proc_rdata = '0;
        if (hit) begin
            proc_rdata = data_arr[idx][word_lsb +: 32];
        end
    end

    always_comb begin
        state_n     = state;
        mem_read_n  = mem_read;
        mem_write_n = mem_write;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        fill        = 1'b0;
        store       = 1'b0;
        case (state)
            COMPARE: begin
                if (req) begin
                    if (hit) begin
                        // A simultaneous read+write is handled as a write.
                        store = proc_write;
                    end else if (valid[idx] && dirty[idx]) begin
                        state_n     = WRITEBACK;
                        mem_write_n = 1'b1;
                        mem_addr_n  = {tag_arr[idx], idx};
                        mem_wdata_n = data_arr[idx];
                    end else begin
                        state_n    = ALLOCATE;
                        mem_read_n = 1'b1;
                        mem_addr_n = proc_addr[ADDR_W-1:2];
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    state_n     = ALLOCATE;
                    mem_write_n = 1'b0;
                    mem_read_n  = 1'b1;
                    mem_addr_n  = proc_addr[ADDR_W-1:2];
                end
            end
            ALLOCATE: begin
                if (mem_ready) begin
                    state_n    = COMPARE;
                    mem_read_n = 1'b0;
                    fill       = 1'b1;
                end
            end
            default: begin
                state_n = COMPARE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COMPARE;
            valid     <= '0;
            dirty     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            mem_read  <= mem_read_n;
            mem_write <= mem_write_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if (fill) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end else if (store) begin
                dirty[idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_arr[idx]  <= req_tag;
            data_arr[idx] <= mem_rdata;
        end else if (store) begin
            data_arr[idx][word_lsb +: 32] <= proc_wdata;
        end
    end

endmodule
